// File: rtl/cache_line_fill_ctrl.sv
// Cache line fill controller: optional dirty-victim write-back, then a full
// line read from the memory controller's fetch_mem_* ports.
// Optional feature macro: CACHE_FILL_CRIT_WORD_FIRST_EN (critical word first).
module cache_line_fill_ctrl #(
    parameter int unsigned mem_depth  = 32,
    parameter int unsigned data_width = 32,
    parameter int unsigned line_words = 4,
    localparam int unsigned AW = $clog2(mem_depth),
    localparam int unsigned OW = $clog2(line_words)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [AW-1:0]         req_fill_addr,
    input  logic                  req_wb,
    input  logic [AW-1:0]         req_wb_addr,
    output logic                  victim_ren,
    output logic [OW-1:0]         victim_ridx,
    input  logic [data_width-1:0] victim_rdata,
    output logic                  fill_we,
    output logic [OW-1:0]         fill_idx,
    output logic [data_width-1:0] fill_data,
    output logic [AW-1:0]         fetch_mem_raddr,
    output logic                  fetch_mem_ren,
    input  logic                  fetch_mem_rready,
    input  logic [data_width-1:0] fetch_mem_rdata,
    input  logic                  fetch_mem_rdata_valid,
    output logic [AW-1:0]         fetch_mem_waddr,
    output logic                  fetch_mem_wen,
    output logic [data_width-1:0] fetch_mem_wdata,
    input  logic                  fetch_mem_wready,
    output logic                  done
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    ,
    output logic                  crit_valid
`endif
);

    localparam logic [OW:0]   LineCnt = (OW+1)'(line_words);
    localparam logic [OW-1:0] LastIdx = OW'(line_words - 1);

    typedef enum logic [2:0] {StIdle, StWbLoad, StWbWrite, StFill, StDone} state_e;

    state_e                 state_q, state_d;
    logic [AW-OW-1:0]       fill_line_q, wb_line_q;
    logic [OW-1:0]          start_q;
    logic [OW:0]            ld_cnt_q;   // victim reads issued
    logic                   cap_vld_q;  // victim data arrives this cycle
    logic [OW-1:0]          cap_idx_q;
    logic [OW-1:0]          wcnt_q;     // write handshakes completed
    logic [OW:0]            icnt_q;     // read handshakes issued
    logic [OW-1:0]          rcnt_q;     // read responses received
    logic [data_width-1:0]  line_buf_q [line_words];
    logic [OW-1:0]          rd_word, fill_word, start_d;
    logic                   accept;

    // Low address bits that do not select anything in this configuration.
    logic unused_addr_bits;
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    assign start_d          = req_fill_addr[OW-1:0];
    assign unused_addr_bits = ^req_wb_addr[OW-1:0];
`else
    assign start_d          = '0;
    assign unused_addr_bits = ^{req_wb_addr[OW-1:0], req_fill_addr[OW-1:0]};
`endif

    assign accept    = req_valid && req_ready;
    assign rd_word   = start_q + icnt_q[OW-1:0];
    assign fill_word = start_q + rcnt_q;

    // Next-state and strobe/output decode; data outputs forced to 0 when their strobe is low.
    always_comb begin
        state_d         = state_q;
        req_ready       = 1'b0;
        victim_ren      = 1'b0;
        fetch_mem_ren   = 1'b0;
        fetch_mem_wen   = 1'b0;
        fill_we         = 1'b0;
        done            = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) state_d = req_wb ? StWbLoad : StFill;
            end
            StWbLoad: begin
                victim_ren = (ld_cnt_q < LineCnt);
                if (cap_vld_q && cap_idx_q == LastIdx) state_d = StWbWrite;
            end
            StWbWrite: begin
                fetch_mem_wen = 1'b1;
                if (fetch_mem_wready && wcnt_q == LastIdx) state_d = StFill;
            end
            StFill: begin
                fetch_mem_ren = (icnt_q < LineCnt);
                if (fetch_mem_rdata_valid) begin
                    fill_we = 1'b1;
                    if (rcnt_q == LastIdx) state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        victim_ridx     = victim_ren ? ld_cnt_q[OW-1:0] : '0;
        fetch_mem_raddr = fetch_mem_ren ? {fill_line_q, rd_word} : '0;
        fetch_mem_waddr = fetch_mem_wen ? {wb_line_q, wcnt_q} : '0;
        fetch_mem_wdata = fetch_mem_wen ? line_buf_q[wcnt_q] : '0;
        fill_idx        = fill_we ? fill_word : '0;
        fill_data       = fill_we ? fetch_mem_rdata : '0;
    end

`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    // First returned word of the line is the missed word.
    always_comb begin
        crit_valid = fill_we && (rcnt_q == '0);
    end
`endif

    // State, latched request and progress counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            fill_line_q <= '0;
            wb_line_q   <= '0;
            start_q     <= '0;
            ld_cnt_q    <= '0;
            cap_vld_q   <= 1'b0;
            cap_idx_q   <= '0;
            wcnt_q      <= '0;
            icnt_q      <= '0;
            rcnt_q      <= '0;
        end else begin
            state_q   <= state_d;
            cap_vld_q <= victim_ren;
            cap_idx_q <= victim_ridx;
            if (accept) begin
                fill_line_q <= req_fill_addr[AW-1:OW];
                wb_line_q   <= req_wb_addr[AW-1:OW];
                start_q     <= start_d;
                ld_cnt_q    <= '0;
                wcnt_q      <= '0;
                icnt_q      <= '0;
                rcnt_q      <= '0;
            end else begin
                if (victim_ren)                         ld_cnt_q <= ld_cnt_q + 1'b1;
                if (fetch_mem_wen && fetch_mem_wready)  wcnt_q   <= wcnt_q + 1'b1;
                if (fetch_mem_ren && fetch_mem_rready)  icnt_q   <= icnt_q + 1'b1;
                if (fill_we)                            rcnt_q   <= rcnt_q + 1'b1;
            end
        end
    end

    // Victim line buffer; deliberately not reset, only written by captures.
    always_ff @(posedge clk) begin
        if (cap_vld_q) line_buf_q[cap_idx_q] <= victim_rdata;
    end

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Self-checking bench for cache_line_fill_ctrl: table-driven misses plus a
// mid-operation reset sequence. Honours CACHE_FILL_CRIT_WORD_FIRST_EN.
module tb_cache_line_fill_ctrl;

`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    localparam bit Crit = 1'b1;
`else
    localparam bit Crit = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wb;
    logic [4:0]  req_fill_addr, req_wb_addr;
    logic        victim_ren;
    logic [1:0]  victim_ridx;
    logic [31:0] victim_rdata;
    logic        fill_we;
    logic [1:0]  fill_idx;
    logic [31:0] fill_data;
    logic [4:0]  fetch_mem_raddr, fetch_mem_waddr;
    logic        fetch_mem_ren, fetch_mem_rready, fetch_mem_rdata_valid;
    logic [31:0] fetch_mem_rdata, fetch_mem_wdata;
    logic        fetch_mem_wen, fetch_mem_wready;
    logic        done;
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    logic        crit_valid;
`endif

    cache_line_fill_ctrl #(.mem_depth(32), .data_width(32), .line_words(4)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_fill_addr         (req_fill_addr),
        .req_wb                (req_wb),
        .req_wb_addr           (req_wb_addr),
        .victim_ren            (victim_ren),
        .victim_ridx           (victim_ridx),
        .victim_rdata          (victim_rdata),
        .fill_we               (fill_we),
        .fill_idx              (fill_idx),
        .fill_data             (fill_data),
        .fetch_mem_raddr       (fetch_mem_raddr),
        .fetch_mem_ren         (fetch_mem_ren),
        .fetch_mem_rready      (fetch_mem_rready),
        .fetch_mem_rdata       (fetch_mem_rdata),
        .fetch_mem_rdata_valid (fetch_mem_rdata_valid),
        .fetch_mem_waddr       (fetch_mem_waddr),
        .fetch_mem_wen         (fetch_mem_wen),
        .fetch_mem_wdata       (fetch_mem_wdata),
        .fetch_mem_wready      (fetch_mem_wready),
        .done                  (done)
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
        ,
        .crit_valid            (crit_valid)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [4:0] a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    function automatic logic [31:0] vic_val(input logic [1:0] i);
        return 32'h0000_00A0 + 32'(i);
    endfunction

    typedef struct {
        logic [4:0] fill_addr;
        bit         wb;
        logic [4:0] wb_addr;
        int         rmode;    // 0: rready always 1, 1: toggling
        bit         stall;    // hold wready low 3 cycles on 2nd write
        bit         foreign;  // stray rdata_valid pulse while idle
        int         lat;      // expected done - accept, -1 = not checked
    } vec_t;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;

    // Monitor logs (written only by the negedge monitor).
    logic [4:0]  rlog[$];
    logic [4:0]  wa_log[$];
    logic [31:0] wd_log[$];
    logic [1:0]  fi_log[$];
    logic [31:0] fd_log[$];
    logic [4:0]  sa_log[$];
    logic [31:0] sd_log[$];
    logic [1:0]  cr_log[$];
    int          stall_seen = 0;
    int          done_count = 0;
    int          done_cyc = 0;
    int          acc_cyc = 0;
    bit          rd_hs_n = 0, wr_hs_n = 0, vren_n = 0, foreign_n = 0;
    logic [4:0]  rd_a_n = '0, wr_a_n = '0;
    logic [31:0] wr_d_n = '0;
    logic [1:0]  vidx_n = '0;

    // Controls written only by the stimulus process.
    int          rmode = 0;
    bit          stall_en = 0;
    bit          foreign_req = 0;
    int          wbase = 0, sbase = 0;

    // Memory-side model state (written only by the memory process).
    logic [31:0] mem [32];
    bit          mem_init = 0;
    bit          tog = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the DUT mid-cycle.
    always @(negedge clk) begin
        rd_hs_n   <= fetch_mem_ren && fetch_mem_rready;
        rd_a_n    <= fetch_mem_raddr;
        wr_hs_n   <= fetch_mem_wen && fetch_mem_wready;
        wr_a_n    <= fetch_mem_waddr;
        wr_d_n    <= fetch_mem_wdata;
        vren_n    <= victim_ren;
        vidx_n    <= victim_ridx;
        foreign_n <= foreign_req;
        if (fetch_mem_ren && fetch_mem_rready) rlog.push_back(fetch_mem_raddr);
        if (fetch_mem_wen && fetch_mem_wready) begin
            wa_log.push_back(fetch_mem_waddr);
            wd_log.push_back(fetch_mem_wdata);
        end
        if (fetch_mem_wen && !fetch_mem_wready) begin
            stall_seen <= stall_seen + 1;
            sa_log.push_back(fetch_mem_waddr);
            sd_log.push_back(fetch_mem_wdata);
        end
        if (fill_we) begin
            fi_log.push_back(fill_idx);
            fd_log.push_back(fill_data);
        end
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
        if (crit_valid) cr_log.push_back(fill_idx);
`endif
        if (req_valid && req_ready) acc_cyc <= cyc;
        if (done) begin
            done_count <= done_count + 1;
            done_cyc   <= cyc;
        end
    end

    // Memory controller, arbiter grants and cache data array.
    always @(posedge clk) begin
        #1;
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] = init_val(5'(i));
            mem_init = 1;
        end
        fetch_mem_rdata_valid = rd_hs_n || foreign_n;
        fetch_mem_rdata       = rd_hs_n ? mem[rd_a_n] : 32'hDEAD_BEEF;
        if (wr_hs_n) mem[wr_a_n] = wr_d_n;
        victim_rdata = vren_n ? vic_val(vidx_n) : 32'h0;
        tog = ~tog;
        fetch_mem_rready = (rmode == 1) ? tog : 1'b1;
        fetch_mem_wready = !(stall_en && (wa_log.size() - wbase == 1) && (stall_seen - sbase < 3));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        int rb, wb, fb, sb, cb, db, t, st;
        logic [1:0] w;
        rmode = v.rmode;
        if (v.foreign) begin
            @(posedge clk); #1 foreign_req = 1;
            @(posedge clk); #1 foreign_req = 0;
            repeat (2) @(posedge clk);
        end
        @(posedge clk); #1;
        rb = rlog.size(); wb = wa_log.size(); fb = fi_log.size();
        sb = sa_log.size(); cb = cr_log.size(); db = done_count;
        wbase = wb; sbase = stall_seen; stall_en = v.stall;
        req_valid = 1; req_fill_addr = v.fill_addr; req_wb = v.wb; req_wb_addr = v.wb_addr;
        @(posedge clk); #1;
        req_valid = 0; req_wb = 0;
        t = 0;
        while (done_count == db && t < 200) begin
            @(posedge clk);
            t++;
        end
        check($sformatf("v%0d_done_pulses", vi), 32'(done_count - db), 32'd1);
        st = Crit ? int'(v.fill_addr[1:0]) : 0;
        check($sformatf("v%0d_rd_count", vi), 32'(rlog.size() - rb), 32'd4);
        check($sformatf("v%0d_fill_count", vi), 32'(fi_log.size() - fb), 32'd4);
        for (int k = 0; k < 4; k++) begin
            w = 2'(st + k);
            if (rb + k < rlog.size())
                check($sformatf("v%0d_raddr%0d", vi, k), 32'(rlog[rb+k]), 32'({v.fill_addr[4:2], w}));
            if (fb + k < fi_log.size()) begin
                check($sformatf("v%0d_fill_idx%0d", vi, k), 32'(fi_log[fb+k]), 32'(w));
                check($sformatf("v%0d_fill_data%0d", vi, k), fd_log[fb+k],
                      init_val({v.fill_addr[4:2], w}));
            end
        end
        check($sformatf("v%0d_wr_count", vi), 32'(wa_log.size() - wb), v.wb ? 32'd4 : 32'd0);
        if (v.wb) begin
            for (int k = 0; k < 4; k++) begin
                if (wb + k < wa_log.size()) begin
                    check($sformatf("v%0d_waddr%0d", vi, k), 32'(wa_log[wb+k]),
                          32'({v.wb_addr[4:2], 2'(k)}));
                    check($sformatf("v%0d_wdata%0d", vi, k), wd_log[wb+k], vic_val(2'(k)));
                end
            end
        end
        check($sformatf("v%0d_stall_cycles", vi), 32'(sa_log.size() - sb), v.stall ? 32'd3 : 32'd0);
        for (int k = sb; k < sa_log.size(); k++) begin
            check($sformatf("v%0d_stall_waddr", vi), 32'(sa_log[k]), 32'h15);
            check($sformatf("v%0d_stall_wdata", vi), sd_log[k], vic_val(2'd1));
        end
        if (v.lat >= 0)
            check($sformatf("v%0d_done_latency", vi), 32'(done_cyc - acc_cyc), 32'(v.lat));
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
        check($sformatf("v%0d_crit_count", vi), 32'(cr_log.size() - cb), 32'd1);
        if (cb < cr_log.size())
            check($sformatf("v%0d_crit_idx", vi), 32'(cr_log[cb]), 32'(st));
`endif
        stall_en = 0;
        rmode = 0;
    endtask

    vec_t vecs[5];

    initial begin
        int t, fb;
        vecs[0] = '{5'h0A, 1'b0, 5'h00, 0, 1'b0, 1'b0, 6};
        vecs[1] = '{5'h04, 1'b1, 5'h14, 0, 1'b0, 1'b0, 15};
        vecs[2] = '{5'h04, 1'b1, 5'h14, 0, 1'b1, 1'b0, 18};
        vecs[3] = '{5'h11, 1'b0, 5'h00, 1, 1'b0, 1'b1, -1};
        vecs[4] = '{5'h0E, 1'b0, 5'h00, 0, 1'b0, 1'b0, 6};

        rst = 1; req_valid = 0; req_wb = 0; req_fill_addr = '0; req_wb_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_ren", 32'(fetch_mem_ren), 32'd0);
        check("reset_wen", 32'(fetch_mem_wen), 32'd0);
        check("reset_victim_ren", 32'(victim_ren), 32'd0);
        check("reset_fill_we", 32'(fill_we), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_raddr", 32'(fetch_mem_raddr), 32'd0);
        check("reset_waddr", 32'(fetch_mem_waddr), 32'd0);
        rst = 0;

        for (int i = 0; i < 5; i++) begin
            run_vec(i, vecs[i]);
            if (i == 1) check("mem_readback_14", mem[5'h14], vic_val(2'd0));
        end

        // Reset after the second returned word, then a fresh request.
        @(posedge clk); #1;
        fb = fi_log.size();
        req_valid = 1; req_fill_addr = 5'h08; req_wb = 0;
        @(posedge clk); #1;
        req_valid = 0;
        t = 0;
        while (fi_log.size() - fb < 2 && t < 50) begin
            @(posedge clk);
            t++;
        end
        check("rst_two_fills_seen", 32'(fi_log.size() - fb), 32'd2);
        #1 rst = 1;
        @(posedge clk); #1;
        check("rst_mid_ren", 32'(fetch_mem_ren), 32'd0);
        check("rst_mid_wen", 32'(fetch_mem_wen), 32'd0);
        check("rst_mid_fill_we", 32'(fill_we), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_req_ready", 32'(req_ready), 32'd1);
        rst = 0;
        run_vec(5, '{5'h1C, 1'b0, 5'h00, 0, 1'b0, 1'b0, 6});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

endmodule
